// File: rtl/gpu_line_pkg.sv
// gpu_line_pkg: shared types and constants for the line-buffer reader slice.
//   MAX_PIXELS : line_buffer capacity in entries
//   COORD_W    : width of one x or y coordinate
//   ENTRY_W    : width of one packed (x,y) entry
//   IDX_W      : width of the entry index / pixel count
//   pixel_t    : packed {x, y}, x in the upper byte as in line_buffer
//   reader_state_t : reader FSM states
package gpu_line_pkg;

    localparam int unsigned MAX_PIXELS = 260;
    localparam int unsigned COORD_W    = 8;
    localparam int unsigned ENTRY_W    = 2 * COORD_W;
    localparam int unsigned IDX_W      = 9;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } reader_state_t;

    // Clamp a requested pixel count to the buffer capacity.
    function automatic logic [IDX_W-1:0] sat_count(input logic [IDX_W-1:0] n,
                                                   input logic [IDX_W-1:0] cap);
        return (n > cap) ? cap : n;
    endfunction

endpackage

// File: rtl/line_idx_counter.sv
// line_idx_counter: entry index for the line-buffer reader.
//   clk, n_rst : clock, asynchronous active-low reset
//   clr        : force index to 0 (wins over en)
//   en         : advance index by one
//   count      : number of valid entries
//   idx        : current entry index
//   at_last    : idx == count-1
module line_idx_counter
    import gpu_line_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [IDX_W-1:0] count,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);

    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx     = idx_q;
    // count=0 never reaches STREAM, so the wrapped count-1 is never matched.
    assign at_last = (idx_q == (count - IDX_W'(1)));

endmodule

// File: rtl/line_buffer_reader.sv
// line_buffer_reader: captures a packed Bresenham line on a load pulse and
// streams its (x,y) entries one per beat over a valid/ready handshake.
//   clk, n_rst   : clock, asynchronous active-low reset
//   load         : one-cycle capture pulse (ignored while a line is in flight)
//   line_buffer  : packed entries, entry i = {x, y} at bits [16i+15:16i]
//   num_pixels   : valid entries from entry 0 (saturates at MAX_PIXELS)
//   pix_ready    : downstream accepts the current beat
//   pix_x/pix_y  : current coordinate
//   pix_valid    : pix_x/pix_y hold a valid beat
//   busy         : streaming in progress
//   done         : one-cycle pulse after the last entry is consumed
// Optional feature: define LINE_READER_BOUNDS_CLIP_EN to drop entries with
// x >= SCREEN_W or y >= SCREEN_H (each dropped entry costs one idle cycle).
module line_buffer_reader #(
    parameter int unsigned MAX_PIXELS = gpu_line_pkg::MAX_PIXELS,
    parameter int unsigned COORD_W    = gpu_line_pkg::COORD_W
`ifdef LINE_READER_BOUNDS_CLIP_EN
    ,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120
`endif
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          load,
    input  logic [MAX_PIXELS*2*COORD_W-1:0] line_buffer,
    input  logic [8:0]                    num_pixels,
    input  logic                          pix_ready,
    output logic [COORD_W-1:0]            pix_x,
    output logic [COORD_W-1:0]            pix_y,
    output logic                          pix_valid,
    output logic                          busy,
    output logic                          done
);

    import gpu_line_pkg::*;

    localparam int unsigned EW   = 2 * COORD_W;
    localparam int unsigned LB_W = MAX_PIXELS * EW;

    reader_state_t     state_q, state_d;
    logic [LB_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]  count_q, count_d;
    pixel_t            pix_q, pix_d;
    logic              pix_valid_q, pix_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  idx, nxt_idx, sat_n;
    logic              at_last, ctr_clr, ctr_en, adv;
    pixel_t            first_entry, nxt_entry;
    logic              first_inb, nxt_inb;

    line_idx_counter u_idx (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .count   (count_q),
        .idx     (idx),
        .at_last (at_last)
    );

    assign sat_n       = sat_count(num_pixels, IDX_W'(MAX_PIXELS));
    assign nxt_idx     = idx + IDX_W'(1);
    assign first_entry = pixel_t'(line_buffer[EW-1:0]);
    // Only consumed when !at_last, so nxt_idx stays inside the store.
    assign nxt_entry   = pixel_t'(buf_q[int'(nxt_idx)*EW +: EW]);

`ifdef LINE_READER_BOUNDS_CLIP_EN
    assign first_inb = (32'(first_entry.x) < SCREEN_W) && (32'(first_entry.y) < SCREEN_H);
    assign nxt_inb   = (32'(nxt_entry.x) < SCREEN_W) && (32'(nxt_entry.y) < SCREEN_H);
`else
    assign first_inb = 1'b1;
    assign nxt_inb   = 1'b1;
`endif

    // A held valid beat advances only on ready; a skipped (invalid) slot
    // advances unconditionally, which is the one-cycle skip cost.
    assign adv = pix_valid_q ? pix_ready : 1'b1;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        count_d     = count_q;
        pix_d       = pix_q;
        pix_valid_d = pix_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                ctr_clr = 1'b1;
                if (load) begin
                    buf_d   = line_buffer;
                    count_d = sat_n;
                    if (sat_n == '0) begin
                        state_d = FINISH;
                    end else begin
                        pix_d       = first_entry;
                        pix_valid_d = first_inb;
                        busy_d      = 1'b1;
                        state_d     = STREAM;
                    end
                end
            end
            STREAM: begin
                if (adv) begin
                    if (at_last) begin
                        pix_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        ctr_clr     = 1'b1;
                        state_d     = FINISH;
                    end else begin
                        ctr_en      = 1'b1;
                        pix_d       = nxt_entry;
                        pix_valid_d = nxt_inb;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                ctr_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            count_q     <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix_x     = pix_q.x;
    assign pix_y     = pix_q.y;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_line_buffer_reader.sv
module tb_line_buffer_reader;

    localparam int LB_W = 260 * 16;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            load;
    logic [LB_W-1:0] line_buffer;
    logic [8:0]      num_pixels;
    logic            pix_ready;
    logic [7:0]      pix_x, pix_y;
    logic            pix_valid, busy, done;

    logic [LB_W-1:0] buf_a, buf_b, buf_c;
    int checks   = 0;
    int failures = 0;

    line_buffer_reader dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .load        (load),
        .line_buffer (line_buffer),
        .num_pixels  (num_pixels),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;        // expected-entry pattern / buffer
        int n;          // num_pixels driven
        int mode;       // 0: ready tied 1, 1: ready 1,0,0 repeating
        int exp_beats;  // beats that must be delivered
    } vec_t;

    // sel 0: diagonal (16+i,16+i); sel 1: (i, 255-i); sel 2: clip line
    function automatic logic [15:0] exp_entry(input int sel, input int i);
        logic [7:0] a, b;
        case (sel)
            0: begin a = 8'(16 + i); b = a; end
            1: begin a = 8'(i); b = 8'(255 - i); end
            default: begin a = (i == 0) ? 8'd10 : 8'd30; b = a; end
        endcase
        return {a, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_line(input logic [LB_W-1:0] b, input int n, input bit expect_beat);
        line_buffer = b;
        num_pixels  = 9'(n);
        load        = 1'b1;
        step();
        load = 1'b0;
        check("first_valid", {31'd0, pix_valid}, {31'd0, expect_beat});
        check("first_busy",  {31'd0, busy},      {31'd0, expect_beat});
    endtask

    // Consumes a line, checking beat order/values, hold under backpressure,
    // and that done arrives exactly two cycles after the last transfer
    // (or after the load cycle for an empty line). inject_at >= 0 pulses a
    // competing load with buf_b during that beat.
    task automatic collect(input int sel, input int exp_n, input int mode,
                           input int inject_at, input string tag);
        int got, last_x;
        bit pv, pr, finished;
        logic [7:0] px, py;
        got = 0; last_x = -1; pv = 0; pr = 0; finished = 0; px = 0; py = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            pix_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            load      = 1'b0;
            if (pv && !pr)
                check({tag, "_hold"}, {15'd0, pix_valid, pix_x, pix_y}, {15'd0, 1'b1, px, py});
            if (pix_valid)
                check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (exp_n == 0)
                check({tag, "_quiet"}, {30'd0, pix_valid, busy}, 32'd0);
            if (done) begin
                check({tag, "_beats"}, got, exp_n);
                check({tag, "_done_gap"}, cyc - last_x, 2);
                finished = 1;
            end else if (pix_valid && pix_ready) begin
                check({tag, "_beat"}, {16'd0, pix_x, pix_y}, {16'd0, exp_entry(sel, got)});
                if (inject_at == got) begin
                    line_buffer = buf_b;
                    num_pixels  = 9'd5;
                    load        = 1'b1;
                end
                got++;
                last_x = cyc;
            end
            pv = pix_valid; pr = pix_ready; px = pix_x; py = pix_y;
            step();
        end
        load = 1'b0;
        if (!finished) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
        end else begin
            check({tag, "_done_width"}, {31'd0, done}, 32'd0);
            check({tag, "_idle_busy"},  {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int got;
        vecs[0] = '{sel: 0, n: 49,  mode: 0, exp_beats: 49};
        vecs[1] = '{sel: 0, n: 49,  mode: 1, exp_beats: 49};
        vecs[2] = '{sel: 0, n: 0,   mode: 0, exp_beats: 0};
        vecs[3] = '{sel: 0, n: 300, mode: 0, exp_beats: 260};
        vecs[4] = '{sel: 1, n: 1,   mode: 1, exp_beats: 1};
        vecs[5] = '{sel: 1, n: 261, mode: 1, exp_beats: 260};

        buf_a = '0; buf_b = '0; buf_c = '0;
        for (int i = 0; i < 260; i++) begin
            buf_a[16*i +: 16] = exp_entry(0, i);
            buf_b[16*i +: 16] = exp_entry(1, i);
        end
        buf_c[15:0]  = {8'd10,  8'd10};
        buf_c[31:16] = {8'd200, 8'd5};
        buf_c[47:32] = {8'd20,  8'd130};
        buf_c[63:48] = {8'd30,  8'd30};

        n_rst = 1'b0; load = 1'b0; pix_ready = 1'b0;
        line_buffer = '0; num_pixels = '0;
        step();
        step();
        check("reset_outputs", {13'd0, pix_x, pix_y, pix_valid, busy, done}, 32'd0);
        n_rst = 1'b1;
        step();
        check("post_reset_outputs", {13'd0, pix_x, pix_y, pix_valid, busy, done}, 32'd0);

`ifndef LINE_READER_BOUNDS_CLIP_EN
        for (int v = 0; v < 6; v++) begin
            load_line(vecs[v].sel == 0 ? buf_a : buf_b, vecs[v].n, vecs[v].exp_beats != 0);
            collect(vecs[v].sel, vecs[v].exp_beats, vecs[v].mode, -1, $sformatf("vec%0d", v));
        end

        // Competing load mid-line is ignored; a load right after done is taken.
        load_line(buf_a, 49, 1'b1);
        collect(0, 49, 0, 10, "midload");
        load_line(buf_b, 5, 1'b1);
        collect(1, 5, 0, -1, "afterdone");
`else
        load_line(buf_c, 4, 1'b1);
        collect(2, 2, 0, -1, "clip");
`endif

        // Reset while beat 20 is presented: async clear, no done, clean restart.
        load_line(buf_a, 49, 1'b1);
        pix_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            if (pix_valid && pix_ready) got++;
            step();
        end
        check("rst_reach_beat20", got, 20);
        check("rst_beat20_value", {16'd0, pix_x, pix_y}, {16'd0, exp_entry(0, 20)});
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_async_clear", {13'd0, pix_x, pix_y, pix_valid, busy, done}, 32'd0);
        step();
        check("rst_held_no_done", {29'd0, pix_valid, busy, done}, 32'd0);
        n_rst = 1'b1;
        step();
        check("rst_release_no_done", {29'd0, pix_valid, busy, done}, 32'd0);
        step();
        check("rst_still_no_done", {31'd0, done}, 32'd0);
        load_line(buf_a, 49, 1'b1);
        collect(0, 49, 0, -1, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
